// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and the blocks that drive its ports.
package fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 8;

  // Write-arbiter FSM: IDLE picks a producer, BURST holds the grant.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of an index into n items (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin first-one finder. Scans req starting one past
// last_id and wrapping modulo N_REQ; reports the first asserted index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_id,
  output logic             found,
  output logic [IDW-1:0]   idx
);

  // cand[k] is the producer visited at step k+1 of the scan.
  logic [IDW-1:0] cand [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum = {1'b0, last_id} + (IDW+1)'(gi + 1);
    assign cand[gi] = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ))
                                                : sum[IDW-1:0];
  end

  // Walk the scan backwards so the earliest asserted candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: shares the FIFO write side among N_REQ
// valid/ready producers, granting one at a time for bursts of at most
// MAX_BURST words and never writing while the FIFO reports full.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = FIFO_DW,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_we,
  output logic [DW-1:0]              fifo_din,
  input  logic                       fifo_full,
  output logic [idx_width(N_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = idx_width(N_REQ);
  localparam int CW  = $clog2(MAX_BURST) + 1;

  arb_state_t     state_q;
  logic [IDW-1:0] grant_id_q;
  logic [IDW-1:0] last_id_q;
  logic [CW-1:0]  burst_cnt_q;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           gnt_valid;
  logic           gnt_last;
  logic           xfer;
  logic           at_limit;

  // Producer data split into one word per producer for the output mux.
  logic [DW-1:0] data_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DW +: DW];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req     (req_valid),
    .last_id (last_id_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign busy      = (state_q == BURST);
  assign grant_id  = grant_id_q;
  assign gnt_valid = req_valid[grant_id_q];
  assign gnt_last  = req_last[grant_id_q];
  // A word moves only when granted, offered, and the FIFO has room. Reset
  // suppresses the write so an in-flight word is never half-accepted.
  assign xfer      = busy & gnt_valid & ~fifo_full & ~rst;
  assign at_limit  = (burst_cnt_q == CW'(MAX_BURST - 1));

  assign fifo_we   = xfer;
  assign fifo_din  = busy ? data_arr[grant_id_q] : '0;

  // Ready goes only to the granted producer, and only when its word is taken.
  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_q] = xfer;
  end

  // Arbitration FSM: pick in IDLE, count and release in BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_id_q   <= IDW'(N_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q  <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (!gnt_valid) begin
            // Producer went quiet: give the port away rather than wait.
            state_q   <= IDLE;
            last_id_q <= grant_id_q;
          end else if (xfer) begin
            burst_cnt_q <= burst_cnt_q + CW'(1);
            if (gnt_last || at_limit) begin
              state_q   <= IDLE;
              last_id_q <= grant_id_q;
            end
          end
          // Valid with FIFO full: stall with grant and count frozen.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter. The driver advances a
// spec-level reference model each cycle and queues the expected outputs and
// FIFO writes; an independent monitor compares them on the falling edge.
module tb_fifo_wr_arbiter;

  localparam int NP = 4;
  localparam int DWT = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req_valid = '0;
  logic [NP*DWT-1:0] req_data = '0;
  logic [NP-1:0]     req_last = '0;
  logic [NP-1:0]     req_ready;
  logic              fifo_we;
  logic [DWT-1:0]    fifo_din;
  logic              fifo_full = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(.N_REQ(NP), .DW(DWT), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_we   (fifo_we),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy;
    int gid;
    int ready;
    int we;
    int din;
  } cyc_t;

  typedef struct {
    int gid;
    int data;
  } wr_t;

  cyc_t cq[$];
  wr_t  wq[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;
  bit chk_en = 1'b0;

  // Reference model state (spec level): is a grant held, by whom, how many
  // words it has moved, and who was served last.
  int m_busy  = 0;
  int m_owner = 0;
  int m_words = 0;
  int m_ptr   = NP - 1;

  // Producer state: a word is offered until the arbiter takes it.
  bit v [NP];
  int d [NP];
  bit l [NP];
  bit xfer_prev = 1'b0;
  int xfer_id_prev = 0;

  function automatic void check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  task automatic run(input int ncyc, input int pv, input int pl, input int pf,
                     input int pr, input bit force_rst);
    for (int c = 0; c < ncyc; c++) begin
      bit r;
      bit full;
      bit found;
      cyc_t e;
      wr_t  w;
      @(posedge clk);
      #1;
      // Producers: retire the word taken last cycle, maybe offer a new one.
      for (int i = 0; i < NP; i++) begin
        if (xfer_prev && xfer_id_prev == i) v[i] = 1'b0;
        if (!v[i]) begin
          v[i] = (int'($urandom_range(99)) < pv);
          d[i] = int'($urandom_range(255));
          l[i] = v[i] && (int'($urandom_range(99)) < pl);
        end
      end
      full = (int'($urandom_range(99)) < pf);
      r    = force_rst || (int'($urandom_range(99)) < pr);
      for (int i = 0; i < NP; i++) begin
        req_valid[i]          = v[i];
        req_data[i*DWT +: DWT] = 8'(d[i]);
        req_last[i]           = l[i];
      end
      fifo_full = full;
      rst       = r;

      // Expected outputs for this cycle.
      e.busy  = m_busy;
      e.gid   = m_owner;
      e.we    = (m_busy != 0 && v[m_owner] && !full && !r) ? 1 : 0;
      e.ready = (e.we != 0) ? (1 << m_owner) : 0;
      e.din   = (m_busy != 0) ? d[m_owner] : 0;
      cq.push_back(e);
      if (e.we != 0) begin
        w.gid  = m_owner;
        w.data = d[m_owner];
        wq.push_back(w);
      end
      chk_en = 1'b1;

      // Advance the reference model to the next cycle.
      xfer_prev    = (e.we != 0);
      xfer_id_prev = m_owner;
      if (r) begin
        m_busy = 0; m_owner = 0; m_words = 0; m_ptr = NP - 1;
      end else if (m_busy == 0) begin
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          int idx;
          idx = (m_ptr + k) % NP;
          if (!found && v[idx]) begin
            found = 1'b1; m_owner = idx; m_words = 0; m_busy = 1;
          end
        end
      end else if (!v[m_owner]) begin
        m_busy = 0; m_ptr = m_owner;
      end else if (e.we != 0) begin
        m_words++;
        if (l[m_owner] || m_words == MB) begin
          m_busy = 0; m_ptr = m_owner;
        end
      end
    end
  endtask

  // Monitor: compares every cycle's outputs and every FIFO write.
  always @(negedge clk) begin
    if (chk_en) begin
      cyc_t e;
      wr_t  w;
      if (cq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL cycle_queue: got empty, expected an entry (t=%0t)", $time);
      end else begin
        e = cq.pop_front();
        check("busy", int'(busy), e.busy);
        check("grant_id", int'(grant_id), e.gid);
        check("req_ready", int'(req_ready), e.ready);
        check("fifo_we", int'(fifo_we), e.we);
        check("fifo_din", int'(fifo_din), e.din);
      end
      if (fifo_we) begin
        n_wr++;
        $display("wr t=%0t src=%0d data=%02h", $time, grant_id, fifo_din);
        check("we_while_full", int'(fifo_full), 0);
        if (wq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: got data %02h, expected none", fifo_din);
        end else begin
          w = wq.pop_front();
          check("wr_data", int'(fifo_din), w.data);
          check("wr_src", int'(grant_id), w.gid);
        end
      end
    end
  end

  initial begin
    int w0;
    for (int i = 0; i < NP; i++) begin
      v[i] = 1'b0; d[i] = 0; l[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset held with every producer valid: nothing may be accepted.
    run(2, 100, 0, 0, 0, 1'b1);
    // Fairness and throughput: 0,1,2,3,0 with 4 words per 5 cycles.
    w0 = n_wr;
    run(20, 100, 0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("fairness_words", n_wr - w0, 16);
    // Mixed traffic: short bursts, last markers, full stalls, valid drops.
    run(300, 60, 25, 20, 0, 1'b0);
    // Same with occasional mid-burst resets.
    run(300, 70, 15, 15, 3, 1'b0);
    // Heavy contention, mostly max-length bursts.
    run(200, 90, 5, 10, 0, 1'b0);
    // Drain: no new words, held words complete.
    run(8, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    check("writes_outstanding", wq.size(), 0);
    check("cycles_outstanding", cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
